// File: rtl/uart_tx_sequencer.sv
// ---------------------------------------------------------------------------
// uart_tx_sequencer
//
// Frame controller for the UART transmit path. A parallel word is captured
// from the host write interface and sent as one frame:
//     start(0), DATA_BITS data bits LSB first, parity, stop(1)
// Each bit lasts CLKS_PER_BIT clocks, timed by an internal baud counter.
// The block does not drive the line itself; it steers an external 4:1 mux.
//
// Mux select encoding {S0,S1}:
//     00 = start (constant 0)
//     01 = Data_Bit
//     10 = Parity_Bit
//     11 = stop / idle (constant 1)
//
// Parameters
//     CLKS_PER_BIT  clocks per UART bit (>= 1)
//     DATA_BITS     data bits per frame (5..8)
//     PARITY_ODD    0 = even parity, 1 = odd parity
//
// Ports
//     clk         in   system clock, rising edge
//     rst_n       in   asynchronous reset, active low
//     tx_start    in   send request, only looked at while tx_busy = 0
//     tx_data     in   word to send, captured when the request is accepted
//     tx_busy     out  high for the whole frame (start through stop)
//     tx_done     out  one-cycle pulse in the first idle cycle after stop
//     S0, S1      out  mux select lines
//     Data_Bit    out  current data bit (0 outside the data phase)
//     Parity_Bit  out  parity of the captured word, held until next accept
//
// All outputs come straight from flops. Their next values are derived from
// the next state, so the outputs change on the same edge as the state.
// ---------------------------------------------------------------------------
module uart_tx_sequencer #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 S0,
    output logic                 S1,
    output logic                 Data_Bit,
    output logic                 Parity_Bit
);

    // Counter widths. A one-clock bit still needs a 1-bit counter.
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t                 state_reg,    state_next;
    logic [BAUD_W-1:0]      baud_reg,     baud_next;
    logic [BIT_W-1:0]       bit_reg,      bit_next;
    logic [DATA_BITS-1:0]   data_reg,     data_next;
    logic                   parity_reg,   parity_next;
    logic                   s0_reg,       s0_next;
    logic                   s1_reg,       s1_next;
    logic                   data_bit_reg, data_bit_next;
    logic                   busy_reg,     busy_next;
    logic                   done_reg,     done_next;

    logic                   baud_wrap;
    logic                   parity_calc;

    // Last clock of the current bit; every state/bit advance happens here.
    assign baud_wrap = (baud_reg == BAUD_LAST);

    // Parity of the incoming word, taken at accept time.
    assign parity_calc = (^tx_data) ^ PARITY_ODD;

    // -----------------------------------------------------------------------
    // State register and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            baud_reg     <= '0;
            bit_reg      <= '0;
            data_reg     <= '0;
            parity_reg   <= 1'b0;
            s0_reg       <= 1'b1;
            s1_reg       <= 1'b1;
            data_bit_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            baud_reg     <= baud_next;
            bit_reg      <= bit_next;
            data_reg     <= data_next;
            parity_reg   <= parity_next;
            s0_reg       <= s0_next;
            s1_reg       <= s1_next;
            data_bit_reg <= data_bit_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state, counters and registered-output values
    // -----------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        baud_next     = baud_reg;
        bit_next      = bit_reg;
        data_next     = data_reg;
        parity_next   = parity_reg;
        done_next     = 1'b0;
        s0_next       = 1'b1;
        s1_next       = 1'b1;
        data_bit_next = 1'b0;
        busy_next     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // Capture word and parity together so Parity_Bit is
                // stable for the whole frame and afterwards.
                if (tx_start) begin
                    state_next  = ST_START;
                    baud_next   = '0;
                    bit_next    = '0;
                    data_next   = tx_data;
                    parity_next = parity_calc;
                end
            end
            ST_START: begin
                if (baud_wrap) begin
                    state_next = ST_DATA;
                    bit_next   = '0;
                end
            end
            ST_DATA: begin
                if (baud_wrap) begin
                    if (bit_reg == BIT_LAST) begin
                        state_next = ST_PARITY;
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (baud_wrap) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (baud_wrap) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // The baud counter only runs inside a frame and always leaves a
        // frame at zero, so a new frame starts with a full-length start bit.
        if (state_reg != ST_IDLE) begin
            baud_next = baud_wrap ? '0 : baud_reg + 1'b1;
        end

        // Outputs follow the state being entered so they line up with it.
        case (state_next)
            ST_START: begin
                s0_next = 1'b0;
                s1_next = 1'b0;
            end
            ST_DATA: begin
                s0_next       = 1'b0;
                s1_next       = 1'b1;
                data_bit_next = data_next[bit_next];
            end
            ST_PARITY: begin
                s0_next = 1'b1;
                s1_next = 1'b0;
            end
            default: begin
                s0_next = 1'b1;
                s1_next = 1'b1;
            end
        endcase

        busy_next = (state_next != ST_IDLE);
    end

    assign tx_busy    = busy_reg;
    assign tx_done    = done_reg;
    assign S0         = s0_reg;
    assign S1         = s1_reg;
    assign Data_Bit   = data_bit_reg;
    assign Parity_Bit = parity_reg;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_sequencer
//
// Two DUT instances run side by side:
//   inst0: CLKS_PER_BIT=4, DATA_BITS=8, even parity
//   inst1: CLKS_PER_BIT=1, DATA_BITS=8, odd parity
// Each instance has a stimulus process that decides, from its own model of
// when the sequencer is free, which requests get accepted and pushes the
// expected frame into a queue. A separate monitor compares every cycle of
// the DUT outputs against the frame at the head of that queue.
// ---------------------------------------------------------------------------
module tb_uart_tx_sequencer;

    localparam int D      = 8;
    localparam int N_INST = 2;

    typedef struct {
        logic [7:0]  d;
        logic        par;
        logic [10:0] bits;   // line value per bit slot: start, d[0..7], parity, stop
        int          a;      // cycle count at which the request is accepted
    } frame_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(input int g, input string name,
                                input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL inst%0d %s @cyc %0d: got 0x%0h expected 0x%0h",
                         g, name, cyc, act, exp);
        end
    endfunction

    for (genvar gi = 0; gi < N_INST; gi++) begin : g_inst
        localparam int C        = (gi == 0) ? 4 : 1;
        localparam bit P        = (gi == 0) ? 1'b0 : 1'b1;
        localparam int FRAME    = (D + 3) * C;
        localparam int RST_AT   = 4 * C + 3;
        localparam int RAND_CYC = (gi == 0) ? 700 : 250;

        logic       rst_n;
        logic       tx_start;
        logic [7:0] tx_data;
        logic       busy, done, s0, s1, data_bit, par_bit;

        frame_t exp_q[$];
        int     next_free  = 0;
        int     n_sent     = 0;
        int     n_done     = 0;
        int     n_abort    = 0;
        bit     fin        = 1'b0;
        bit     final_done = 1'b0;

        uart_tx_sequencer #(
            .CLKS_PER_BIT (C),
            .DATA_BITS    (D),
            .PARITY_ODD   (P)
        ) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .tx_start   (tx_start),
            .tx_data    (tx_data),
            .tx_busy    (busy),
            .tx_done    (done),
            .S0         (s0),
            .S1         (s1),
            .Data_Bit   (data_bit),
            .Parity_Bit (par_bit)
        );

        // Called just after a rising edge; the inputs are sampled at the
        // next edge, after which cyc equals cyc+1.
        task automatic drive(input logic s, input logic [7:0] d, output bit acc);
            frame_t f;
            tx_start = s;
            tx_data  = d;
            acc      = 1'b0;
            if (s && rst_n && (cyc + 1 >= next_free)) begin
                f.d    = d;
                f.par  = 1'($countones(d) % 2) ^ P;
                f.bits = {1'b1, f.par, d, 1'b0};
                f.a    = cyc + 1;
                exp_q.push_back(f);
                // Free again in the tx_done cycle, one cycle after the frame.
                next_free = f.a + FRAME + 1;
                n_sent++;
                acc = 1'b1;
            end
            @(posedge clk);
            #2;
        endtask

        task automatic send(input logic [7:0] d, output int a);
            bit acc;
            acc = 1'b0;
            a   = 0;
            while (!acc) begin
                a = cyc + 1;
                drive(1'b1, d, acc);
            end
        endtask

        task automatic idle(input int n);
            bit acc;
            repeat (n) drive(1'b0, 8'($urandom), acc);
        endtask

        task automatic wait_free();
            bit acc;
            while (cyc + 1 < next_free) drive(1'b0, 8'($urandom), acc);
        endtask

        function automatic void chk_outs(input string tag, input logic [1:0] esel,
                                         input logic edata, input logic epar,
                                         input logic ebusy, input logic edone,
                                         input logic eline);
            logic [1:0] sel;
            logic       line;
            sel  = {s0, s1};
            line = (sel == 2'b00) ? 1'b0 :
                   (sel == 2'b01) ? data_bit :
                   (sel == 2'b10) ? par_bit : 1'b1;
            chk(gi, {tag, "_sel"},      32'(sel),      32'(esel));
            chk(gi, {tag, "_data_bit"}, 32'(data_bit), 32'(edata));
            chk(gi, {tag, "_parity"},   32'(par_bit),  32'(epar));
            chk(gi, {tag, "_busy"},     32'(busy),     32'(ebusy));
            chk(gi, {tag, "_done"},     32'(done),     32'(edone));
            chk(gi, {tag, "_line"},     32'(line),     32'(eline));
        endfunction

        // Stimulus
        initial begin
            int a;
            bit acc;
            rst_n    = 1'b1;
            tx_start = 1'b0;
            tx_data  = 8'h00;
            #1 rst_n = 1'b0;
            repeat (3) @(posedge clk);
            #2 rst_n = 1'b1;
            idle(2);

            // Single frame
            send((gi == 0) ? 8'hA5 : 8'h81, a);
            wait_free();
            idle(2);

            // Request while busy is dropped
            send(8'h3C, a);
            while (cyc + 1 < a + 9) drive(1'b0, 8'($urandom), acc);
            drive(1'b1, 8'hFF, acc);
            wait_free();
            idle(1);

            // tx_start held high across two frames
            send(8'h55, a);
            send(8'hAA, a);
            wait_free();
            idle(3);

            // Parity sense check word
            send(8'h07, a);
            wait_free();
            idle(2);

            // Reset in the middle of the data phase
            send(8'hC3, a);
            while (cyc < a + RST_AT) drive(1'b0, 8'($urandom), acc);
            tx_start  = 1'b0;
            rst_n     = 1'b0;
            next_free = 0;
            repeat (2) begin
                @(posedge clk);
                #2;
            end
            rst_n = 1'b1;
            send(8'h96, a);
            wait_free();
            idle(1);

            // Random requests and data, including requests during frames
            // and in the tx_done cycle
            for (int i = 0; i < RAND_CYC; i++)
                drive($urandom_range(0, 2) == 0, 8'($urandom), acc);
            tx_start = 1'b0;
            wait_free();
            idle(3);
            fin = 1'b1;
        end

        // Monitor / scoreboard
        initial begin
            frame_t     f;
            int         k;
            int         b;
            logic [1:0] esel;
            logic       edata;
            logic       last_par;
            last_par = 1'b0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    chk_outs("reset", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                    last_par = 1'b0;
                    while (exp_q.size() > 0 && exp_q[0].a <= cyc) begin
                        f = exp_q.pop_front();
                        n_abort++;
                        $display("inst%0d frame data=0x%02h accepted@%0d aborted by reset @%0d",
                                 gi, f.d, f.a, cyc);
                    end
                end else if (exp_q.size() > 0 && exp_q[0].a <= cyc) begin
                    f = exp_q[0];
                    k = cyc - f.a;
                    if (k == 0) last_par = f.par;
                    if (k < FRAME) begin
                        b     = k / C;
                        esel  = (b == 0) ? 2'b00 :
                                (b <= D) ? 2'b01 :
                                (b == D + 1) ? 2'b10 : 2'b11;
                        edata = (b >= 1 && b <= D) ? f.bits[b] : 1'b0;
                        chk_outs("frame", esel, edata, f.par, 1'b1, 1'b0, f.bits[b]);
                    end else begin
                        chk_outs("done", 2'b11, 1'b0, last_par, 1'b0, 1'b1, 1'b1);
                        void'(exp_q.pop_front());
                        n_done++;
                        $display("inst%0d frame data=0x%02h parity=%0d accepted@%0d tx_done@%0d",
                                 gi, f.d, f.par, f.a, cyc);
                    end
                end else begin
                    chk_outs("idle", 2'b11, 1'b0, last_par, 1'b0, 1'b0, 1'b1);
                end

                if (fin && !final_done) begin
                    chk(gi, "queue_empty", 32'(exp_q.size()), 32'd0);
                    chk(gi, "frames_accounted", 32'(n_done + n_abort), 32'(n_sent));
                    final_done = 1'b1;
                end
            end
        end
    end

    initial begin
        int waited;
        waited = 0;
        while (!(g_inst[0].final_done && g_inst[1].final_done) && waited < 20000) begin
            @(posedge clk);
            waited++;
        end
        if (!(g_inst[0].final_done && g_inst[1].final_done)) begin
            $display("FAIL timeout: run did not complete within %0d cycles", waited);
            $fatal(1, "run did not complete");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
